// File: rtl/rca_seq_if.sv
// Operand and result port bundle for rca_seq.
// Handshake rule: a transfer occurs on a rising clk edge where valid and ready are both 1; valid never depends on ready.
interface rca_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, overflow, busy
  );
endinterface

// File: rtl/rca_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one SLICE-bit ripple slice,
// least-significant slice first, with the inter-slice carry held in a register.
module rca_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  rca_seq_if.slave   bus,
  output logic [1:0] state_o
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int SW     = WIDTH + 1;
  localparam logic [WIDTH:0] SMASK = SW'({SLICE{1'b1}});

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic [31:0]      base;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   slice_res;
  logic             last;

  // Shifting instead of a variable part-select keeps index widths clean for any SLICE.
  assign base      = 32'(k_q) * 32'(SLICE);
  assign a_sl      = SLICE'(a_q >> base);
  assign b_sl      = SLICE'(b_q >> base);
  assign slice_res = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);
  assign last      = (k_q == KW'(NSLICE - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
          k_d     = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(SMASK << base)) | (SW'(slice_res[SLICE-1:0]) << base);
        carry_d = slice_res[SLICE];
        k_d     = k_q + 1'b1;
        if (last) begin
          sum_d[WIDTH] = slice_res[SLICE];
          // The top slice's MSB is the result sign bit, so overflow is decided here.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_res[SLICE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.overflow  = ovf_q;
  assign state_o       = state_q;
endmodule

// File: doc/rca_seq.md
# rca_seq

Parametrised multi-cycle ripple-carry adder/subtractor that generalises the 4-bit RCA to WIDTH bits. It reuses one SLICE-bit ripple slice over WIDTH/SLICE cycles, least-significant slice first, carrying between cycles in a register. It sits behind a valid/ready operand port and holds its result on a valid/ready result port, so datapath blocks can share one narrow adder instead of a full-width one.

## Interface
- WIDTH, default 16: operand width in bits; WIDTH must be a multiple of SLICE.
- SLICE, default 4: bits added per cycle; 1 <= SLICE <= WIDTH. NSLICE = WIDTH/SLICE.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a, b, cin and sub are valid.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1, cin ignored.
- out_valid  output  1  sum and overflow are valid; equals (state == DONE).
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH+1  result; sum[WIDTH] is carry-out (for sub, 1 means no borrow).
- overflow  output  1  signed overflow of the WIDTH-bit result.
- busy  output  1  equals (state == RUN).

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- IDLE -> RUN when in_valid & in_ready at a rising edge (the accept edge):
  - capture a;
  - capture b_eff = sub ? ~b : b;
  - set carry register = sub ? 1 : cin;
  - clear slice counter k = 0;
  - clear the sum register.
- RUN, each edge:
  - slice k computes {c, s} = a[k*SLICE +: SLICE] + b_eff[k*SLICE +: SLICE] + carry;
  - write s into sum[k*SLICE +: SLICE];
  - carry <= c; k <= k+1.
  - On the edge that processes k = NSLICE-1: write sum[WIDTH] = c and overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]); go to DONE.
- DONE:
  - sum and overflow are held stable.
  - Leave for IDLE on the edge where out_ready = 1.
  - in_valid is ignored.
- in_valid is ignored outside IDLE, so operands offered in RUN or DONE are not captured and no operation is started.
- Operand inputs may change freely after the accept edge; the captured copies are used.
- Arithmetic is modulo 2^WIDTH plus carry bit:
  - sum equals a + b + cin (add) or a + ~b + 1 (sub), zero-extended to WIDTH+1 bits.
- SLICE = WIDTH degenerates to a single RUN cycle; this case must work.

## Timing
- Reset values, asserted asynchronously:
  - state IDLE, in_ready 1, out_valid 0, busy 0;
  - sum 0, overflow 0;
  - k 0, carry 0.
- Latency: out_valid rises NSLICE edges after the accept edge.
- The result handshake completes on the first edge with out_valid & out_ready. in_ready is 1 in the next cycle.
- Best-case initiation interval is NSLICE+2 cycles, with out_ready tied high and in_valid held high.
- No accept in the same cycle as the result handshake: in_ready is 0 throughout DONE.
- Partial sum bits may be observed on sum during RUN; they are undefined for the consumer until out_valid.
- Reset mid-RUN or mid-DONE:
  - every output returns to its reset value immediately;
  - the in-flight operation is discarded;
  - the first accept after reset_n deasserts behaves as from power-up.
- All outputs are registers or decodes of the state register. There is no combinational path from inputs to outputs.

## Test plan
- WIDTH=16, SLICE=4: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x10000, overflow=0; out_valid exactly 4 edges after accept; busy high for those 4 cycles.
- a=0x7FFF, b=0x0001 -> sum=0x08000, overflow=1. Then a=0x1234, b=0x4321, cin=1 -> sum=0x05556, overflow=0.
- sub=1, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0x0FFFE (borrow: sum[16]=0), overflow=0. Then a=0x8000, b=0x0001 -> sum=0x17FFF, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum and out_valid stable, in_ready=0, nothing captured. Release out_ready -> IDLE next cycle.
- Assert reset_n=0 after 2 RUN edges -> all outputs take reset values asynchronously. After release, a=0x00FF, b=0x0001 -> sum=0x00100.
- Random: 150 vectors each at WIDTH=8/SLICE=2, WIDTH=16/SLICE=16 and WIDTH=32/SLICE=1, with out_ready randomly stalled. Compare against a+b+cin or a-b reference; log a, b, sum, expected and a pass bit to a file.
